// File: rtl/uart_dbus_pkg.sv
// Shared definitions for the UART-to-dbus debug bridge.
// Optional bus timeout lives behind UART_DBUS_BUS_TIMEOUT_EN.
package uart_dbus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_BUS,
    S_RESP
  } state_e;

  localparam logic [1:0] CMD_RD = 2'b01;
  localparam logic [1:0] CMD_WR = 2'b10;

  localparam logic [7:0] ACK_DEF = 8'hA5;
  localparam logic [7:0] ERR_DEF = 8'hEE;

  localparam int TXQ_DEPTH = 5;

  // A zero byteenable field in CMD means all four lanes.
  function automatic logic [3:0] cmd_be(input logic [7:0] cmd);
    return (cmd[7:4] == 4'h0) ? 4'hF : cmd[7:4];
  endfunction

  function automatic logic cmd_legal(input logic [7:0] cmd);
    return (cmd[1:0] == CMD_RD) || (cmd[1:0] == CMD_WR);
  endfunction

endpackage

// File: rtl/uart_dbus_txq.sv
// Response shifter: loads a word plus trailer byte, or a trailer
// alone, and drains it LSB first under tx_valid/tx_ready.
module uart_dbus_txq
  import uart_dbus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        word_en_i,
  input  logic [31:0] word_i,
  input  logic [7:0]  trailer_i,
  input  logic        tx_ready_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  output logic        last_o
);

  logic [TXQ_DEPTH-1:0][7:0] buf_q;
  logic [2:0]                cnt_q;
  logic                      valid_q;
  logic                      take;

  assign take = valid_q && tx_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q   <= '0;
      cnt_q   <= 3'd0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      if (word_en_i) begin
        buf_q <= {trailer_i, word_i};
        cnt_q <= 3'd5;
      end else begin
        buf_q <= {32'h0, trailer_i};
        cnt_q <= 3'd1;
      end
    end else if (take) begin
      buf_q   <= {8'h00, buf_q[TXQ_DEPTH-1:1]};
      cnt_q   <= cnt_q - 3'd1;
      valid_q <= (cnt_q != 3'd1);
    end
  end

  assign tx_data_o  = buf_q[0];
  assign tx_valid_o = valid_q;
  assign last_o     = take && (cnt_q == 3'd1);

endmodule

// File: rtl/uart_dbus_master.sv
// UART byte stream to single-word dbus transactions, results as bytes.
// Define UART_DBUS_BUS_TIMEOUT_EN to abort requests stalled too long.
module uart_dbus_master
  import uart_dbus_pkg::*;
#(
  parameter logic [23:0] RX_GAP_CYCLES      = 24'd5000000,
  parameter logic [15:0] BUS_TIMEOUT_CYCLES = 16'd4096,
  parameter logic [7:0]  ACK_BYTE           = ACK_DEF,
  parameter logic [7:0]  ERR_BYTE           = ERR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] bus_address,
  output logic [3:0]  bus_byteenable,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_wrdata,
  input  logic [31:0] bus_rddata,
  input  logic        bus_stall,
  output logic        busy,
  output logic        overrun
);

  state_e      state_q;
  logic        wr_op_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  cnt_q;
  logic [23:0] gap_q;
  logic        rd_q;
  logic        wr_q;
  logic        ovr_q;

  logic        gap_to;
  logic        bus_done;
  logic        bus_abort;
  logic        ld_ok;
  logic        ld_err;
  logic        tx_last;

  assign gap_to   = (gap_q == RX_GAP_CYCLES);
  assign bus_done = (rd_q || wr_q) && !bus_stall;

`ifdef UART_DBUS_BUS_TIMEOUT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= 16'd0;
    end else if ((state_q == S_BUS) && bus_stall) begin
      stall_q <= stall_q + 16'd1;
    end else begin
      stall_q <= 16'd0;
    end
  end

  assign bus_abort = (state_q == S_BUS) && bus_stall &&
                     (stall_q == BUS_TIMEOUT_CYCLES - 16'd1);
`else
  logic unused_tmo;
  assign unused_tmo = ^BUS_TIMEOUT_CYCLES;
  assign bus_abort  = 1'b0;
`endif

  assign ld_ok  = (state_q == S_BUS) && bus_done;
  assign ld_err = ((state_q == S_IDLE) && rx_valid && !cmd_legal(rx_data))
                || bus_abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wr_op_q <= 1'b0;
      be_q    <= 4'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      cnt_q   <= 2'd0;
      gap_q   <= 24'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (rx_valid) begin
            if (cmd_legal(rx_data)) begin
              wr_op_q <= (rx_data[1:0] == CMD_WR);
              be_q    <= cmd_be(rx_data);
              cnt_q   <= 2'd0;
              gap_q   <= 24'd0;
              state_q <= S_ADDR;
            end else begin
              state_q <= S_RESP;
            end
          end
        end
        S_ADDR, S_WDATA: begin
          // Timeout beats a byte arriving on the same cycle.
          if (gap_to) begin
            gap_q   <= 24'd0;
            ovr_q   <= rx_valid;
            state_q <= S_IDLE;
          end else if (rx_valid) begin
            gap_q <= 24'd0;
            cnt_q <= cnt_q + 2'd1;
            if (state_q == S_ADDR) begin
              addr_q[{cnt_q, 3'b000} +: 8] <= rx_data;
            end else begin
              wdata_q[{cnt_q, 3'b000} +: 8] <= rx_data;
            end
            if (cnt_q == 2'd3) begin
              if ((state_q == S_WDATA) || !wr_op_q) begin
                rd_q    <= !wr_op_q;
                wr_q    <= wr_op_q;
                state_q <= S_BUS;
              end else begin
                state_q <= S_WDATA;
              end
            end
          end else begin
            gap_q <= gap_q + 24'd1;
          end
        end
        S_BUS: begin
          ovr_q <= rx_valid;
          if (bus_done || bus_abort) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          ovr_q <= rx_valid;
          if (tx_last) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  uart_dbus_txq u_txq (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ld_ok || ld_err),
    .word_en_i  (ld_ok && !wr_op_q),
    .word_i     (bus_rddata),
    .trailer_i  (ld_err ? ERR_BYTE : ACK_BYTE),
    .tx_ready_i (tx_ready),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .last_o     (tx_last)
  );

  assign bus_address    = {addr_q[31:2], 2'b00};
  assign bus_byteenable = be_q;
  assign bus_wrdata     = wdata_q;
  assign bus_read       = rd_q;
  assign bus_write      = wr_q;
  assign busy           = (state_q != S_IDLE);
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_uart_dbus_master.sv
// Randomized scoreboard bench for uart_dbus_master.
// Bus and tx agents check against queues filled by the frame model.
module tb_uart_dbus_master;

  localparam logic [23:0] GAP = 24'd64;
  localparam logic [15:0] TMO = 16'd40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [31:0] bus_address;
  logic [3:0]  bus_byteenable;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_wrdata;
  logic [31:0] bus_rddata = 32'h0;
  logic        bus_stall = 1'b0;
  logic        busy;
  logic        overrun;

  uart_dbus_master #(
    .RX_GAP_CYCLES      (GAP),
    .BUS_TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .bus_address    (bus_address),
    .bus_byteenable (bus_byteenable),
    .bus_read       (bus_read),
    .bus_write      (bus_write),
    .bus_wrdata     (bus_wrdata),
    .bus_rddata     (bus_rddata),
    .bus_stall      (bus_stall),
    .busy           (busy),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    int          cycles;
  } bus_exp_t;

  bus_exp_t    bus_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] mem[logic [31:0]];

  int vectors = 0;
  int errors = 0;
  int stall_cfg = 0;
  int bp_cycles = 0;
  int ovr_cnt = 0;
  int last_req = 0;

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endfunction

  function automatic void miss(input string nm);
    vectors++;
    errors++;
    $display("FAIL %s: got output, expected none", nm);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  // Bus slave agent and checker
  bit          in_txn = 0;
  int          stall_left = 0;
  int          req_cnt = 0;
  logic [31:0] snap_a;
  logic [31:0] snap_d;
  logic [3:0]  snap_be;

  always @(negedge clk) begin
    if (rst) begin
      bus_stall = 1'b0;
      in_txn = 0;
    end else begin
      bus_rddata = $urandom;
      if (bus_read || bus_write) begin
        if (!in_txn) begin
          in_txn = 1;
          req_cnt = 0;
          stall_left = stall_cfg;
          snap_a = bus_address;
          snap_d = bus_wrdata;
          snap_be = bus_byteenable;
        end else begin
          chk("bus_hold_addr", bus_address, snap_a);
          chk("bus_hold_wdata", bus_wrdata, snap_d);
          chk("bus_hold_be", {28'h0, bus_byteenable}, {28'h0, snap_be});
        end
        req_cnt++;
        if (stall_left > 0) begin
          bus_stall = 1'b1;
          stall_left--;
        end else begin
          bus_stall = 1'b0;
          bus_rddata = mem_rd(bus_address);
          if (bus_q.size() == 0) begin
            miss("bus_unexpected");
          end else begin
            bus_exp_t e;
            e = bus_q.pop_front();
            chk("bus_write", {31'h0, bus_write}, {31'h0, e.wr});
            chk("bus_read", {31'h0, bus_read}, {31'h0, !e.wr});
            chk("bus_addr", bus_address, e.addr);
            chk("bus_be", {28'h0, bus_byteenable}, {28'h0, e.be});
            if (e.wr) chk("bus_wdata", bus_wrdata, e.data);
            chk("bus_cycles", req_cnt, e.cycles);
          end
        end
      end else begin
        if (in_txn) last_req = req_cnt;
        in_txn = 0;
        bus_stall = 1'b0;
      end
    end
  end

  // Tx sink agent and checker
  bit         have_prev = 0;
  logic [7:0] prev_data;
  int         bp_left = 0;

  always @(negedge clk) begin
    if (rst) begin
      tx_ready = 1'b0;
      have_prev = 0;
    end else if (tx_valid) begin
      if (have_prev) chk("tx_hold", {24'h0, tx_data}, {24'h0, prev_data});
      else bp_left = bp_cycles;
      if (bp_left > 0) begin
        tx_ready = 1'b0;
        bp_left--;
        have_prev = 1;
        prev_data = tx_data;
      end else begin
        tx_ready = 1'b1;
        have_prev = 0;
        if (tx_q.size() == 0) miss("tx_unexpected");
        else chk("tx_byte", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
      end
    end else begin
      tx_ready = 1'b0;
      have_prev = 0;
    end
  end

  always @(negedge clk) if (!rst && overrun) ovr_cnt++;

  task automatic send_byte(input logic [7:0] b, input int idle);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (idle) @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!busy && bus_q.size() == 0 && tx_q.size() == 0) return;
    end
    chk("idle_timeout", {31'h0, busy}, 32'h0);
    bus_q.delete();
    tx_q.delete();
  endtask

  // Model: pushes the expected bus access and reply, then sends bytes.
  task automatic do_frame(input logic [7:0] cmd, input logic [31:0] addr,
                          input logic [31:0] data, input int stall,
                          input int bp, input int gap, input bit wait_done);
    logic [1:0]  op;
    logic [3:0]  be;
    logic [31:0] wa;
    logic [31:0] w;
    stall_cfg = stall;
    bp_cycles = bp;
    op = cmd[1:0];
    be = (cmd[7:4] == 4'h0) ? 4'hF : cmd[7:4];
    wa = {addr[31:2], 2'b00};
    if (op == 2'b00 || op == 2'b11) begin
      tx_q.push_back(8'hEE);
      send_byte(cmd, gap);
    end else begin
      bus_q.push_back('{op == 2'b10, wa, be, data, stall + 1});
      if (op == 2'b10) begin
        w = mem_rd(wa);
        for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = data[8*i +: 8];
        mem[wa] = w;
      end else begin
        w = mem_rd(wa);
        for (int i = 0; i < 4; i++) tx_q.push_back(w[8*i +: 8]);
      end
      tx_q.push_back(8'hA5);
      send_byte(cmd, gap);
      for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8], gap);
      if (op == 2'b10)
        for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8], gap);
    end
    if (wait_done) wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ovr;
    logic [7:0] cmd;
    repeat (2) @(negedge clk);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_bus_read", {31'h0, bus_read}, 32'h0);
    chk("rst_bus_write", {31'h0, bus_write}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_overrun", {31'h0, overrun}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst_addr", bus_address, 32'h0);
    chk("rst_wdata", bus_wrdata, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    do_frame(8'hF2, 32'hBFD003F8, 32'h12345678, 0, 0, 0, 1);
    do_frame(8'hF1, 32'hBFD003F8, 32'h0, 0, 0, 0, 1);
    do_frame(8'hF1, 32'hBFD003F8, 32'h0, 7, 0, 1, 1);
    do_frame(8'h03, 32'h0, 32'h0, 0, 0, 0, 1);
    do_frame(8'h32, 32'hBFD003F9, 32'hAABBCCDD, 2, 1, 0, 1);
    do_frame(8'h01, 32'hBFD003F8, 32'h0, 0, 0, 0, 1);

    send_byte(8'hF1, 0);
    send_byte(8'h10, 0);
    send_byte(8'h20, int'(GAP) + 6);
    chk("gap_busy", {31'h0, busy}, 32'h0);
    chk("gap_tx_valid", {31'h0, tx_valid}, 32'h0);
    do_frame(8'h02, 32'h00000040, 32'hCAFEF00D, 0, 0, int'(GAP) - 2, 1);
    do_frame(8'h01, 32'h00000040, 32'h0, 1, 0, 0, 1);

    exp_ovr = ovr_cnt + 1;
    do_frame(8'hF1, 32'h00000040, 32'h0, 0, 10, 0, 0);
    for (int i = 0; i < 200 && !tx_valid; i++) @(negedge clk);
    send_byte(8'h55, 0);
    wait_idle();
    chk("overrun_count", ovr_cnt, exp_ovr);

    for (int n = 0; n < 40; n++) begin
      cmd[7:4] = 4'($urandom);
      cmd[3:2] = 2'($urandom);
      cmd[1:0] = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(1, 2));
      do_frame(cmd, 32'h20000000 + 32'($urandom_range(0, 31)),
               $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), 1);
    end

    stall_cfg = 30;
    send_byte(8'hF2, 0);
    for (int i = 0; i < 8; i++) send_byte(8'h11, 0);
    for (int i = 0; i < 20 && !bus_write; i++) @(negedge clk);
    chk("rst_pre_write", {31'h0, bus_write}, 32'h1);
    #3 rst = 1'b1;
    #1;
    chk("async_write", {31'h0, bus_write}, 32'h0);
    chk("async_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_frame(8'h02, 32'h00000080, 32'h5A5A0001, 0, 0, 0, 1);
    do_frame(8'h01, 32'h00000080, 32'h0, 0, 2, 0, 1);

`ifdef UART_DBUS_BUS_TIMEOUT_EN
    stall_cfg = 1000;
    bp_cycles = 0;
    tx_q.push_back(8'hEE);
    send_byte(8'h01, 0);
    for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
    wait_idle();
    chk("timeout_cycles", last_req, int'(TMO));
`endif

    chk("overrun_final", ovr_cnt, exp_ovr);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/uart_dbus_master.md
Name: uart_dbus_master

Overview:
- Debug bridge that turns a byte stream from a host UART link into single-word transactions on the CPU data bus (dbus) and returns the results as bytes.
- Acts as a dbus initiator, the opposite end from the dbus peripheral slaves (uart_top, gpio_top, ticker, flash_top).
- Sits between a byte-level UART core and a dbus arbiter port, so a PC can peek and poke any peripheral or RAM address without CPU involvement.

Parameters:
- RX_GAP_CYCLES, 24'd5000000: maximum idle clk cycles between bytes of one frame; exceeding it discards the partial frame.
- BUS_TIMEOUT_CYCLES, 16'd4096: maximum cycles a bus request may stay stalled (used only with the optional feature).
- ACK_BYTE, 8'hA5: response byte for success.
- ERR_BYTE, 8'hEE: response byte for error.

Ports:
- clk  in  1  bus clock; all logic in this domain.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte from the UART core.
- rx_valid  in  1  one-cycle strobe; rx_data is valid.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  held high until accepted.
- tx_ready  in  1  the UART core accepts tx_data on a cycle where tx_valid && tx_ready.
- bus_address  out  32  dbus address; bits [1:0] forced to 0.
- bus_byteenable  out  4  dbus byte lanes.
- bus_read  out  1  dbus read request.
- bus_write  out  1  dbus write request.
- bus_wrdata  out  32  dbus write data.
- bus_rddata  in  32  dbus read data.
- bus_stall  in  1  dbus wait request from the slave.
- busy  out  1  high in every state except S_IDLE.
- overrun  out  1  one-cycle pulse when a byte arrives while not accepting.

Behaviour:
- Frame layout: CMD, ADDR0..ADDR3 (little-endian), then DATA0..DATA3 (little-endian) for writes only.
- CMD[1:0]: 2'b01 = read, 2'b10 = write; 00 and 11 are illegal. CMD[7:4] = byteenable; a value of 0 is treated as 4'hF. CMD[3:2] are ignored.
- Reset values: all outputs 0, state S_IDLE, counters 0.
- S_IDLE
  - On rx_valid with a legal CMD: latch op and byteenable, go to S_ADDR with byte count 0.
  - On rx_valid with an illegal CMD: load tx_data = ERR_BYTE and go to S_RESP.
- S_ADDR
  - Shift each byte into address[8*n+7:8*n].
  - After the 4th byte: a read goes to S_BUS; a write goes to S_WDATA.
- S_WDATA: collect 4 bytes in the same way, then go to S_BUS.
- Inter-byte gap: in S_ADDR and S_WDATA, a gap counter resets on every rx_valid. On reaching RX_GAP_CYCLES, the frame is discarded silently and the block returns to S_IDLE with no response.
- S_BUS
  - bus_read or bus_write is asserted from the first cycle in S_BUS. Address, byteenable and wrdata are held stable for the whole request.
  - The transaction completes on the rising edge where the request is high and bus_stall is 0. On that edge, bus_rddata is captured for reads.
  - The request deasserts the next cycle, so every access is exactly one dbus transaction; the minimum is 1 cycle with no stall.
- S_RESP, read: send 4 rddata bytes LSB first, then ACK_BYTE.
- S_RESP, write: send ACK_BYTE only.
- S_RESP handshake: each byte is held on tx_data with tx_valid high until tx_ready. The next byte is presented the cycle after acceptance. After the last byte is accepted, return to S_IDLE.
- Bytes received in S_BUS or S_RESP are dropped and pulse overrun.
- An rx_valid in the same cycle as the gap timeout: the timeout wins and the byte is dropped (overrun pulses).
- Reset asserted mid-operation clears bus_read, bus_write and tx_valid immediately (asynchronously). No partial transaction is retried.

Optional Feature:
- Macro: UART_DBUS_BUS_TIMEOUT_EN.
- Defined: a stall counter runs in S_BUS. If bus_stall stays high for BUS_TIMEOUT_CYCLES consecutive cycles, the request is deasserted and the block sends ERR_BYTE only, then returns to S_IDLE.
- Undefined: the block waits on bus_stall indefinitely; no counter logic is synthesized.

Decomposition:
- Package uart_dbus_pkg holds:
  - state encoding: S_IDLE, S_ADDR, S_WDATA, S_BUS, S_RESP;
  - command opcode constants CMD_RD = 2'b01 and CMD_WR = 2'b10;
  - the ACK and ERR byte defaults.
- One natural sub-module, uart_dbus_txq: a 5-entry response shifter that loads a word plus trailer and drains it under the tx_valid/tx_ready handshake.

Test Plan:
- Write then read:
  - Stimulus: send 8'hF2, address 0xBFD003F8 as bytes F8 03 D0 BF, data 0x12345678 as bytes 78 56 34 12.
  - Expected: one cycle with bus_write = 1, bus_address = 0xBFD003F8, bus_wrdata = 0x12345678, byteenable = 4'hF; then tx byte A5.
  - Then send a read (8'hF1) to the same address with a slave model returning 0x12345678. Expected tx bytes: 78 56 34 12 A5.
- Stall: slave holds bus_stall = 1 for 7 cycles. Expected: bus_read stays high exactly 8 cycles and the captured data is the value present on the 8th cycle.
- Illegal command: CMD 8'h03. Expected: no bus activity and tx byte EE.
- Gap timeout and overrun:
  - Send the CMD and 2 address bytes, then idle for RX_GAP_CYCLES. Expected: no bus access, no tx, busy drops.
  - Send a byte while in S_RESP. Expected: an overrun pulse.
- Backpressure: tx_ready = 0 for 10 cycles per byte. Expected: every response byte is delivered once, in order, with tx_data stable while tx_valid is high.
- Reset mid-operation and bus timeout:
  - Assert rst during S_BUS. Expected: bus_write drops without waiting for a clock edge, and the next frame works normally.
  - With UART_DBUS_BUS_TIMEOUT_EN defined and bus_stall held high permanently, the expected response is EE after BUS_TIMEOUT_CYCLES.
